ifu_axi_fetch: RTL
==================

Name: ifu_axi_fetch

Overview:
Parametrised instruction fetch unit and next-generation IFU for the ysyx_25030093 core.
- Takes a PC from the write-back/next-PC stage over a valid/ready handshake.
- Fetches one instruction through an AXI4-Lite read master of configurable width.
- Presents the instruction, its PC and a fault code to the decode stage over valid/ready.
- Adds over the previous IFU: configurable bus width, misalignment and bus-error reporting, a flush/redirect path that safely drains in-flight reads, and a retired-fetch counter.

Parameters:
ADDR_W, 32, PC and bus address width
DATA_W, 32, AXI read data width; only 32 or 64 are legal
RESET_PC, 32'h8000_0000, first fetch address after reset
CNT_W, 32, width of the fetch counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream next-PC valid
in_ready  out  1  IFU can accept a new PC
in_pc  in  ADDR_W  next PC
out_valid  out  1  fetched instruction valid
out_ready  in  1  decode accepts the instruction
out_inst  out  32  instruction word
out_pc  out  ADDR_W  PC of out_inst
out_fault  out  2  00 none, 01 misaligned PC, 10 bus error
flush  in  1  redirect request; discards current work
flush_pc  in  ADDR_W  redirect target
m_araddr  out  ADDR_W  AXI read address
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_rdata  in  DATA_W  AXI read data
m_rresp  in  2  AXI read response
m_rvalid  in  1  AXI R valid
m_rready  out  1  AXI R ready
fetch_cnt  out  CNT_W  count of instructions handed to decode

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- States: IDLE, REQ, RESP, HOLD.
- Reset values:
  - state = REQ, pc_q = RESET_PC, so the first fetch starts with no upstream handshake.
  - m_arvalid = 1, m_araddr = aligned RESET_PC.
  - out_inst = 0, out_pc = 0, out_fault = 00, fetch_cnt = 0, drop = 0.
- Alignment: m_araddr = pc_q with its low log2(DATA_W/8) bits cleared.
- Lane select: when DATA_W = 64, out_inst = pc_q[2] ? m_rdata[63:32] : m_rdata[31:0]. When DATA_W = 32, out_inst = m_rdata.
- Start rule, applied to a new PC p:
  - If p[1:0] != 0: go to HOLD, out_fault = 01, out_inst = 0, no bus access.
  - Otherwise: go to REQ and assert m_arvalid.
- IDLE:
  - in_ready = ~flush.
  - flush: apply the start rule to flush_pc; flush has priority over in_valid.
  - Otherwise, in_valid & in_ready: latch in_pc, then apply the start rule.
- REQ:
  - m_arvalid is registered and held, together with m_araddr, until m_arvalid & m_arready. Then go to RESP.
- RESP:
  - m_rready = 1 (combinational from state).
  - On m_rvalid with drop = 0: latch out_inst and out_pc; out_fault = (m_rresp != 0) ? 10 : 00; go to HOLD.
  - On m_rvalid with drop = 1: discard the data, clear drop, apply the start rule to the saved redirect PC.
- HOLD:
  - out_valid = (state == HOLD) & ~flush.
  - out_valid & out_ready: go to IDLE and increment fetch_cnt (wraps modulo 2^CNT_W). Faulted instructions also count.
- Flush in REQ or RESP:
  - Set drop and save flush_pc.
  - The AR request is never withdrawn; the outstanding R beat is always drained.
  - A later flush before the drain overwrites the saved PC; the latest one wins.
- Flush in HOLD: discard the held output with no handshake and no count; apply the start rule to flush_pc the next cycle.
- Outside their states, in_ready, m_arvalid and m_rready are 0.
- Only one outstanding AXI read at any time.
- Zero-wait bus timing: from REQ entry, m_arready = 1 and m_rvalid = 1 on the next cycle give out_valid 2 cycles after entering REQ.
- rst mid-transaction returns all state to reset values. The bus slave must also be reset; a stale R beat is not tolerated.

Test Plan:
- Reset, then m_arready = 1 and m_rvalid = 1 immediately with rdata = 32'h00000413 → m_araddr = 32'h80000000; out_valid with out_inst = 32'h00000413, out_pc = 32'h80000000, out_fault = 00; fetch_cnt = 1 after out_ready.
- DATA_W = 64, in_pc = 32'h80000004, rdata = 64'hDEADBEEF_00100093 → m_araddr = 32'h80000000, out_inst = 32'hDEADBEEF.
- in_pc = 32'h80000002 → no m_arvalid; out_valid with out_fault = 01, out_pc = 32'h80000002.
- m_rresp = 2'b10 on the R beat → out_fault = 10; fetch_cnt increments on acceptance.
- Flush with flush_pc = 32'h80000100 while in RESP, with m_rvalid delayed 5 cycles → first beat discarded, no out_valid for it, a new AR at 32'h80000100, and only the redirected instruction delivered.
- Hold out_ready = 0 in HOLD for 10 cycles, then flush → out_valid drops in the flush cycle, fetch_cnt unchanged, and the next m_araddr equals flush_pc.

Source files
------------

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: takes a next PC over valid/ready, reads one
// instruction through an AXI4-Lite read master and hands instruction, PC
// and fault code to decode. A flush redirects fetch; an in-flight read is
// always drained before the redirect target is fetched.
module ifu_axi_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000),
    parameter int unsigned       CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [1:0]        out_fault,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS   = 2'b10;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(DATA_W / 8 - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [ADDR_W-1:0] redir_q, redir_n;
    logic              drop_q, drop_n;
    logic [31:0]       inst_q, inst_n;
    logic [ADDR_W-1:0] opc_q, opc_n;
    logic [1:0]        fault_q, fault_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [31:0]       lane;
    logic              start;
    logic [ADDR_W-1:0] start_pc;

    // Pick the 32-bit instruction lane out of the read beat
    generate
        if (DATA_W == 64) begin : g_lane64
            always_comb lane = pc_q[2] ? m_rdata[63:32] : m_rdata[31:0];
        end else begin : g_lane32
            always_comb lane = m_rdata[31:0];
        end
    endgenerate

    assign in_ready  = (state == IDLE) & ~flush;
    assign out_valid = (state == HOLD) & ~flush;
    assign m_arvalid = (state == REQ);
    assign m_rready  = (state == RESP);
    assign m_araddr  = pc_q & ALIGN_MASK;
    assign out_inst  = inst_q;
    assign out_pc    = opc_q;
    assign out_fault = fault_q;
    assign fetch_cnt = cnt_q;

    // Next-state and datapath update; a new PC funnels through one start rule
    always_comb begin
        state_n  = state;
        pc_n     = pc_q;
        redir_n  = redir_q;
        drop_n   = drop_q;
        inst_n   = inst_q;
        opc_n    = opc_q;
        fault_n  = fault_q;
        cnt_n    = cnt_q;
        start    = 1'b0;
        start_pc = pc_q;

        case (state)
            IDLE: begin
                if (flush) begin
                    start    = 1'b1;
                    start_pc = flush_pc;
                end else if (in_valid) begin
                    start    = 1'b1;
                    start_pc = in_pc;
                end
            end
            REQ: begin
                if (flush) begin
                    drop_n  = 1'b1;
                    redir_n = flush_pc;
                end
                if (m_arready) state_n = RESP;
            end
            RESP: begin
                if (m_rvalid) begin
                    // A flush arriving with the beat is newer than any saved redirect
                    if (flush) begin
                        drop_n   = 1'b0;
                        start    = 1'b1;
                        start_pc = flush_pc;
                    end else if (drop_q) begin
                        drop_n   = 1'b0;
                        start    = 1'b1;
                        start_pc = redir_q;
                    end else begin
                        inst_n  = lane;
                        opc_n   = pc_q;
                        fault_n = (m_rresp != 2'b00) ? FAULT_BUS : FAULT_NONE;
                        state_n = HOLD;
                    end
                end else if (flush) begin
                    drop_n  = 1'b1;
                    redir_n = flush_pc;
                end
            end
            HOLD: begin
                if (flush) begin
                    start    = 1'b1;
                    start_pc = flush_pc;
                end else if (out_ready) begin
                    cnt_n   = cnt_q + CNT_W'(1);
                    state_n = IDLE;
                end
            end
            default: state_n = REQ;
        endcase

        if (start) begin
            pc_n = start_pc;
            if (start_pc[1:0] != 2'b00) begin
                state_n = HOLD;
                inst_n  = '0;
                opc_n   = start_pc;
                fault_n = FAULT_ALIGN;
            end else begin
                state_n = REQ;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= REQ;
            pc_q    <= RESET_PC;
            redir_q <= '0;
            drop_q  <= 1'b0;
            inst_q  <= '0;
            opc_q   <= '0;
            fault_q <= FAULT_NONE;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            redir_q <= redir_n;
            drop_q  <= drop_n;
            inst_q  <= inst_n;
            opc_q   <= opc_n;
            fault_q <= fault_n;
            cnt_q   <= cnt_n;
        end
    end

endmodule
